fp_addsub_seq: RTL and testbench
================================

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored mantissa field width; W = 1+EXP_W+MAN_W, bias = 2^(EXP_W-1)-1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  operands valid
  in_ready  out  1  block can accept operands
  op_a  in  W  operand A, {sign, exp, man}
  op_b  in  W  operand B
  sub  in  1  0: A+B, 1: A-B (B sign inverted at capture)
  out_valid  out  1  result valid
  out_ready  in  1  consumer accepts result
  result  out  W  rounded sum
  flags  out  3  {invalid, overflow, underflow}

Function
REQ-005 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; op_a, op_b and sub are captured on that edge only.
REQ-006 in_ready SHALL equal (state==IDLE); no new operands are taken while an operation or an unconsumed result is pending.
REQ-007 FSM states SHALL be IDLE, ALIGN, ADDSUB, NORM, DONE; IDLE->ALIGN on accept, ALIGN->ADDSUB->NORM->DONE unconditionally, DONE->IDLE on out_ready=1.
REQ-008 ALIGN SHALL classify operands, swap so |A|>=|B| (exp, then mantissa), form hidden-1 mantissas, and right-shift the smaller by the exponent difference into MAN_W+1 bits plus guard, round and sticky.
REQ-009 An exponent difference >= MAN_W+3 SHALL reduce the smaller operand to sticky=1 only (if nonzero).
REQ-010 ADDSUB SHALL add magnitudes when effective signs match, else subtract smaller from larger; result sign is the larger operand's sign.
REQ-011 NORM SHALL normalise in one cycle: carry-out -> shift right 1, exp+1 (shifted-out bit joins sticky); leading zeros -> left shift by leading-zero count, exp minus count.
REQ-012 Rounding SHALL be round-to-nearest-even on guard/round/sticky; mantissa overflow from rounding increments the exponent.
REQ-013 out_valid SHALL rise on the third rising edge after the accepting edge and hold until the out_ready handshake edge.
REQ-014 result and flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-015 Subnormal inputs SHALL be treated as zero of the same sign; a normalised exponent <=0 SHALL produce signed zero with underflow=1.
REQ-016 Exponent >= 2^EXP_W-1 after rounding SHALL produce signed infinity with overflow=1.
REQ-017 Any NaN input, or inf minus inf, SHALL produce canonical quiet NaN {0, all-ones exp, 1 then zeros} with invalid=1.
REQ-018 Inf plus finite SHALL return that infinity, no flags; equal infinities same sign return that infinity.
REQ-019 Exact zero from unlike signs SHALL be +0; (-0)+(-0) SHALL be -0.
REQ-020 Special-case decisions SHALL be made in ALIGN and carried through; latency is identical for all operand classes.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, out_valid=0, result=0, flags=0, independent of clk, including mid-operation.
REQ-022 in_ready SHALL be 1 during and after reset; the first accept may occur on the first rising edge with rst_n=1.

Verification
REQ-023 op_a=0x40600000, op_b=0x40400000, sub=0 -> result 0x40D00000, flags 0, out_valid on 3rd edge after accept.
REQ-024 op_a=0x3F800000, op_b=0x3F800000, sub=1 -> result 0x00000000, flags 0; op_a=0x3F800000, op_b=0x33800000 (tie) -> 0x3F800000.
REQ-025 op_a=0x7F800000, op_b=0xFF800000 -> result 0x7FC00000, flags=3'b100; op_a=op_b=0x7F7FFFFF -> 0x7F800000, flags=3'b010.
REQ-026 Hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-027 Assert rst_n=0 while in ADDSUB -> out_valid=0, result=0 without a clock edge; next operation after release completes correctly.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Sequential floating-point adder/subtractor: IDLE -> ALIGN -> ADDSUB -> NORM -> DONE.
// Round-to-nearest-even, subnormals flushed to zero, one operation in flight.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [2:0]           flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;
  localparam int M1  = M + 1;
  localparam int XW  = M + 3;
  localparam int SW  = XW + 1;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(XW + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} stateType;
  stateType state, nextState;

  logic accept;
  logic [W-1:0] aReg, bReg;

  // Align-stage combinational signals
  logic [EXP_W-1:0] expA, expB, bigExp, smallExp, expDiff;
  logic [MAN_W-1:0] fracA, fracB;
  logic             zeroA, zeroB, infA, infB, nanA, nanB, aGe, isNan, isInf;
  logic [M-1:0]     sigA, sigB, bigSig, smallSig;
  logic [XW-1:0]    wideS, shiftS;
  logic [W-1:0]     specRes;

  // Pipeline registers
  logic             bigSgnR, effSubR, specR;
  logic [EXP_W-1:0] bigExpR;
  logic [XW-1:0]    manLR, manSR;
  logic [W-1:0]     specResR;
  logic [2:0]       specFlagsR;
  logic [SW-1:0]    sumR;

  // Normalise/round combinational signals
  logic [XW-1:0]    lzMan, normMan;
  logic [LZW-1:0]   lz;
  logic [EW-1:0]    normExp, finalExp;
  logic [M1-1:0]    rndMan;
  logic [MAN_W-1:0] fracOut;
  logic             roundUp, uflow, oflow;
  logic [W-1:0]     normRes;
  logic [2:0]       normFlags;

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = ALIGN;
      ALIGN:   nextState = ADDSUB;
      ADDSUB:  nextState = NORM;
      NORM:    nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand classification and magnitude ordering
  assign expA  = aReg[W-2:MAN_W];
  assign expB  = bReg[W-2:MAN_W];
  assign fracA = aReg[MAN_W-1:0];
  assign fracB = bReg[MAN_W-1:0];
  assign zeroA = (expA == '0);
  assign zeroB = (expB == '0);
  assign infA  = (expA == '1) && (fracA == '0);
  assign infB  = (expB == '1) && (fracB == '0);
  assign nanA  = (expA == '1) && (fracA != '0);
  assign nanB  = (expB == '1) && (fracB != '0);
  assign sigA  = zeroA ? '0 : {1'b1, fracA};
  assign sigB  = zeroB ? '0 : {1'b1, fracB};
  assign aGe   = (expA > expB) || ((expA == expB) && (sigA >= sigB));

  assign bigExp   = aGe ? expA : expB;
  assign smallExp = aGe ? expB : expA;
  assign bigSig   = aGe ? sigA : sigB;
  assign smallSig = aGe ? sigB : sigA;
  assign expDiff  = bigExp - smallExp;

  assign isNan   = nanA | nanB | (infA & infB & (aReg[W-1] ^ bReg[W-1]));
  assign isInf   = infA | infB;
  assign specRes = isNan ? QNAN : {infA ? aReg[W-1] : bReg[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  // Smaller operand shifted into mantissa + guard/round/sticky; far operands become sticky only
  always_comb begin
    wideS  = {smallSig, 3'b000};
    shiftS = '0;
    if (int'(expDiff) >= MAN_W + 3) begin
      shiftS[0] = |smallSig;
    end else begin
      shiftS    = wideS >> expDiff;
      shiftS[0] = shiftS[0] | (|(wideS & ~({XW{1'b1}} << expDiff)));
    end
  end

  // Leading-zero normalisation; a carry-out instead shifts right and folds bit 0 into sticky
  always_comb begin
    lzMan   = sumR[XW-1:0];
    lz      = '0;
    normMan = '0;
    normExp = '0;
    for (int unsigned i = 0; i < XW; i++) begin
      if (!lzMan[XW-1]) begin
        lzMan = lzMan << 1;
        lz    = lz + LZW'(1);
      end
    end
    if (sumR[SW-1]) begin
      normMan    = sumR[SW-1:1];
      normMan[0] = sumR[1] | sumR[0];
      normExp    = {2'b00, bigExpR} + EW'(1);
    end else begin
      normMan = lzMan;
      normExp = {2'b00, bigExpR} - EW'(lz);
    end
  end

  assign roundUp  = normMan[2] & (normMan[1] | normMan[0] | normMan[3]);
  assign rndMan   = {1'b0, normMan[XW-1:3]} + M1'(roundUp);
  assign finalExp = normExp + EW'(rndMan[M]);
  assign fracOut  = rndMan[M] ? rndMan[MAN_W:1] : rndMan[MAN_W-1:0];
  assign uflow    = normExp[EW-1] || (normExp == '0);
  assign oflow    = (finalExp >= {2'b00, {EXP_W{1'b1}}});

  always_comb begin
    normRes   = '0;
    normFlags = '0;
    if (specR) begin
      normRes   = specResR;
      normFlags = specFlagsR;
    end else if (sumR == '0) begin
      normRes = {bigSgnR & ~effSubR, {(W-1){1'b0}}};
    end else if (uflow) begin
      normRes   = {bigSgnR, {(W-1){1'b0}}};
      normFlags = 3'b001;
    end else if (oflow) begin
      normRes   = {bigSgnR, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      normFlags = 3'b010;
    end else begin
      normRes = {bigSgnR, finalExp[EXP_W-1:0], fracOut};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg       <= '0;
      bReg       <= '0;
      bigSgnR    <= 1'b0;
      effSubR    <= 1'b0;
      specR      <= 1'b0;
      bigExpR    <= '0;
      manLR      <= '0;
      manSR      <= '0;
      specResR   <= '0;
      specFlagsR <= '0;
      sumR       <= '0;
      result     <= '0;
      flags      <= '0;
    end else begin
      if (accept) begin
        aReg <= op_a;
        bReg <= {op_b[W-1] ^ sub, op_b[W-2:0]};
      end
      if (state == ALIGN) begin
        bigSgnR    <= aGe ? aReg[W-1] : bReg[W-1];
        effSubR    <= aReg[W-1] ^ bReg[W-1];
        bigExpR    <= bigExp;
        manLR      <= {bigSig, 3'b000};
        manSR      <= shiftS;
        specR      <= isNan | isInf;
        specResR   <= specRes;
        specFlagsR <= {isNan, 2'b00};
      end
      if (state == ADDSUB) begin
        sumR <= effSubR ? ({1'b0, manLR} - {1'b0, manSR})
                        : ({1'b0, manLR} + {1'b0, manSR});
      end
      if (state == NORM) begin
        result <= normRes;
        flags  <= normFlags;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq (binary32): directed vector table,
// handshake/reset sequences and random operands against a real-arithmetic model.
module tb_fp_addsub_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [2:0]   flags;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] res;
    logic [2:0]  flg;
  } vecT;
  vecT vecs[$];

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] res, input logic [2:0] flg);
    vecT v;
    v.a = a; v.b = b; v.s = s; v.res = res; v.flg = flg;
    vecs.push_back(v);
  endtask

  function automatic real toReal(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Reference: exact-enough double sum, then RNE to binary32 with the block's flush rules
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic [2:0] f);
    logic        sa, sb, nanA, nanB, infA, infB, neg;
    logic [63:0] d;
    logic [23:0] mant;
    logic [28:0] rem;
    real         sum, mag;
    int          e;
    sa = a[31];
    sb = b[31] ^ s;
    nanA = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nanB = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    infA = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    infB = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    f = 3'b000;
    if (nanA || nanB || (infA && infB && (sa != sb))) begin
      r = 32'h7FC00000; f = 3'b100;
    end else if (infA) begin
      r = {sa, 8'hFF, 23'd0};
    end else if (infB) begin
      r = {sb, 8'hFF, 23'd0};
    end else if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
      r = {sa & sb, 31'd0};
    end else begin
      sum = toReal(a) + toReal({sb, b[30:0]});
      if (sum == 0.0) begin
        r = 32'd0;
      end else begin
        neg  = (sum < 0.0);
        mag  = neg ? -sum : sum;
        d    = $realtobits(mag);
        e    = int'(d[62:52]) - 1023 + 127;
        mant = {1'b0, d[51:29]};
        rem  = d[28:0];
        if (e <= 0) begin
          r = {neg, 31'd0}; f = 3'b001;
        end else begin
          if (rem > 29'h10000000 || (rem == 29'h10000000 && mant[0])) mant = mant + 24'd1;
          if (mant[23]) begin
            e    = e + 1;
            mant = 24'd0;
          end
          if (e >= 255) begin
            r = {neg, 8'hFF, 23'd0}; f = 3'b010;
          end else begin
            r = {neg, 8'(e), mant[22:0]};
          end
        end
      end
    end
  endtask

  task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic s);
    int w = 0;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("inReadyAtAccept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = ~s;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finishOp();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] expRes, input logic [2:0] expFlg);
    int lat;
    startOp(a, b, s);
    waitValid(lat);
    check({tag, ".latency"}, lat, 32'd3);
    check({tag, ".result"}, result, expRes);
    check({tag, ".flags"}, {29'd0, flags}, {29'd0, expFlg});
    finishOp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] a, b, er;
    logic [2:0]  ef;
    logic        s;
    int          ea, eb, mode;

    addVec(32'h40600000, 32'h40400000, 1'b0, 32'h40D00000, 3'b000);
    addVec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
    addVec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    addVec(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
    addVec(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
    addVec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
    addVec(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
    addVec(32'hFF800000, 32'h40A00000, 1'b0, 32'hFF800000, 3'b000);
    addVec(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000);
    addVec(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
    addVec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    addVec(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
    addVec(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);
    addVec(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
    addVec(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
    addVec(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b000);
    addVec(32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000, 3'b000);
    addVec(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000);
    addVec(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 3'b010);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.inReady", {31'd0, in_ready}, 32'd1);
    check("rst.outValid", {31'd0, out_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.flags", {29'd0, flags}, 32'd0);
    #1 rst_n = 1'b1;

    foreach (vecs[i])
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].flg);

    // Back-pressure: result held, new operands refused
    startOp(32'h40600000, 32'h40400000, 1'b0);
    waitValid(lat);
    check("stall.latency", lat, 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_a = $urandom; op_b = $urandom;
      @(posedge clk);
      #1;
      check($sformatf("stall%0d.result", k), result, 32'h40D00000);
      check($sformatf("stall%0d.flags", k), {29'd0, flags}, 32'd0);
      check($sformatf("stall%0d.outValid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d.inReady", k), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    finishOp();
    check("stallRelease.outValid", {31'd0, out_valid}, 32'd0);
    check("stallRelease.inReady", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset in the middle of an operation
    startOp(32'h3F800000, 32'h40000000, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midRst.outValid", {31'd0, out_valid}, 32'd0);
    check("midRst.result", result, 32'd0);
    check("midRst.flags", {29'd0, flags}, 32'd0);
    check("midRst.inReady", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midRst.noSpuriousValid", {31'd0, out_valid}, 32'd0);
    runOp("postRst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);

    // Random operands against the reference model
    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 3);
      ea = $urandom_range(90, 160);
      a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      s = 1'($urandom_range(0, 1));
      case (mode)
        0: eb = ea + $urandom_range(0, 8) - 4;
        1: eb = ea + $urandom_range(0, 60) - 30;
        default: eb = ea;
      endcase
      b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if (mode == 2) b = {a[31] ^ s, a[30:0] ^ (32'($urandom) & 32'h00000FFF)};
      if (mode == 3) b = $urandom;
      model(a, b, s, er, ef);
      runOp($sformatf("rnd%0d", n), a, b, s, er, ef);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
